float_add_pipe: RTL
===================

# float_add_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor with a valid/ready handshake. It is the next generation of the combinational FP16 adder and is the accumulate stage of the CNN convolution/dense datapath. Exponent and mantissa widths are parameters, with FP16 as the default. It adds a per-operation subtract mode, special-value handling and status flags.

## Interface
- EXP_W, 5, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 10, stored mantissa width (hidden bit implicit)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- a  in  1+EXP_W+MAN_W  operand A {sign, exp, man}
- b  in  1+EXP_W+MAN_W  operand B
- sub  in  1  1: result = a - b; 0: result = a + b
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  1+EXP_W+MAN_W  result
- ovf  out  1  result overflowed to infinity
- nan  out  1  result is NaN

## Operation
- Three registered stages:
  - S1 (align): unpack, swap so that |A| ≥ |B|, right-shift the smaller mantissa by the exponent difference into guard/round/sticky bits, classify special values.
  - S2 (add): add or subtract the extended mantissas. Effective sign = sign_a XOR sign_b XOR sub.
  - S3 (normalise/round): leading-zero count, shift, round, pack, set flags.
- Subnormal inputs (exp = 0) are flushed to signed zero. Subnormal results are flushed to +0.
- Exact cancellation gives +0.
- Zero operand: the result is the other operand, with B's sign inverted when sub = 1.
- exp = all-ones, man = 0 is ±Inf. exp = all-ones, man ≠ 0 is NaN.
- Any NaN input, or Inf − Inf, gives the canonical NaN {0, all-ones, 1, 0…} with nan = 1.
- Inf op finite gives that Inf, with ovf = 0.
- Exponent overflow after rounding gives ±Inf with ovf = 1.
- Flags are per-result and valid only with out_valid.

## Timing
- Latency: 3 cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no stall.
- Throughput: one result per cycle.
- Global pipeline enable: en = !out_valid | out_ready.
  - in_ready = en (combinational from out_ready).
  - All stages hold while en = 0.
- Each stage carries a valid bit. Bubbles propagate and are not compressed.
- out_valid, sum and flags stay stable while out_valid & !out_ready.
- Reset: all stage valids = 0, out_valid = 0, sum = 0, ovf = 0, nan = 0.
- Reset asserted mid-operation discards all in-flight results. in_ready = 1 in the first cycle after reset.
- An accept and an output handshake in the same cycle are legal and required for full throughput.

## Configuration
- FLOAT_ADD_RNE_EN defined: round-to-nearest-even using guard/round/sticky. A mantissa carry-out from rounding renormalises and increments the exponent.
- FLOAT_ADD_RNE_EN undefined: truncation (round toward zero), matching the legacy adder. The rounding incrementer and its carry path are not built.
- Latency is identical in both builds.

## Structure
- The shared fp package holds:
  - localparams for field widths and bias
  - canonical NaN and Inf constants
  - the unpacked-operand struct {sign, exp, man, is_zero, is_inf, is_nan}
  - the unpack function
- One sub-module, fp_lzc: a parametrised leading-zero counter used by S3.
- S1/S2 stay inline.

## Test plan
Defaults EXP_W = 5, MAN_W = 10, out_ready = 1 unless stated.
- a = 0x39D2, b = 0x35A1, sub = 0 -> sum = 0x3C51 three cycles later, flags 0.
- a = 0x35A1, b = 0x0000 -> 0x35A1. Then a = 0x0000, b = 0x39D2, sub = 1 -> 0xB9D2.
- a = 0xD0A4, b = 0x4BD6 -> 0xCD5D. Then a = 0x4BD6, b = 0x4BD6, sub = 1 -> 0x0000.
- a = 0x3C03, b = 0x3C00 -> 0x4002 with FLOAT_ADD_RNE_EN, 0x4001 without.
- Special values:
  - 0x7BFF + 0x7BFF -> 0x7C00, ovf = 1.
  - 0x7C00 + 0xFC00 -> 0x7E00, nan = 1.
  - 0x7C00 + 0x3C00 -> 0x7C00, ovf = 0.
- Backpressure and reset:
  - Stream 8 back-to-back operand pairs. Hold out_ready = 0 for cycles 4–7: in_ready falls with it, and all 8 results emerge in order with none dropped or duplicated.
  - Assert rst mid-stream: out_valid = 0 the next cycle, and no stale result appears afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point definitions for the pipelined adder.
// Holds the default FP16 field widths and bias, the canonical NaN/Inf encodings,
// the unpacked-operand struct and the unpack helper used by float_add_pipe.
// The struct is sized for formats up to FP64 so one type serves every width
// parameterisation; callers slice out the bits their format actually uses.
package fp_pkg;

    localparam int FP_EXP_W   = 5;
    localparam int FP_MAN_W   = 10;
    localparam int FP_BIAS    = (1 << (FP_EXP_W - 1)) - 1;
    localparam int FP_EXP_MAX = 11;
    localparam int FP_MAN_MAX = 52;

    localparam logic [FP_EXP_W+FP_MAN_W:0] FP_QNAN = {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};
    localparam logic [FP_EXP_W+FP_MAN_W:0] FP_INF  = {1'b0, {FP_EXP_W{1'b1}}, {FP_MAN_W{1'b0}}};

    typedef struct packed {
        logic                  sign;
        logic [FP_EXP_MAX-1:0] exp;
        logic [FP_MAN_MAX-1:0] man;
        logic                  is_zero;
        logic                  is_inf;
        logic                  is_nan;
    } fp_unp_t;

    // Subnormals (exp = 0) come out as signed zero with a cleared mantissa.
    function automatic fp_unp_t fp_unpack(input logic [63:0] w, input int ew, input int mw);
        logic [63:0] emask;
        logic [63:0] e;
        logic [63:0] m;
        fp_unp_t     u;
        emask     = (64'd1 << ew) - 64'd1;
        e         = (w >> mw) & emask;
        m         = w & ((64'd1 << mw) - 64'd1);
        u.sign    = w[ew+mw];
        u.is_zero = (e == 64'd0);
        u.is_inf  = (e == emask) && (m == 64'd0);
        u.is_nan  = (e == emask) && (m != 64'd0);
        u.exp     = e[FP_EXP_MAX-1:0];
        u.man     = u.is_zero ? '0 : m[FP_MAN_MAX-1:0];
        return u;
    endfunction

endpackage

// File: rtl/float_add_pipe_lzc.sv
// fp_lzc: parametrised leading-zero counter.
// Ports: i_d data word; o_cnt number of leading zeros (W when i_d is zero).
module fp_lzc #(
    parameter int W = 16
) (
    input  logic [W-1:0]           i_d,
    output logic [$clog2(W+1)-1:0] o_cnt
);

    localparam int CW = $clog2(W + 1);

    // Scanning upward lets the highest set bit have the final say.
    always_comb begin
        o_cnt = CW'(W);
        for (int i = 0; i < W; i++)
            if (i_d[i]) o_cnt = CW'(W - 1 - i);
    end

endmodule

// File: rtl/float_add_pipe.sv
// float_add_pipe: three-stage pipelined floating-point adder/subtractor.
// Ports: clk, rst (synchronous, active-high); i_in_valid/o_in_ready operand handshake;
// i_a, i_b operands {sign, exp, man}; i_sub selects a - b; o_out_valid/i_out_ready result
// handshake; o_sum result; o_ovf overflow to infinity; o_nan NaN result.
// Build option FLOAT_ADD_RNE_EN: round-to-nearest-even; otherwise results truncate toward zero.
module float_add_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [EXP_W+MAN_W:0]   i_a,
    input  logic [EXP_W+MAN_W:0]   i_b,
    input  logic                   i_sub,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [EXP_W+MAN_W:0]   o_sum,
    output logic                   o_ovf,
    output logic                   o_nan
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int XW = MAN_W + 4;
    localparam int SW = XW + 1;
    localparam int LW = $clog2(SW + 1);
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    logic             r1_v, r1_s, r1_sub, r1_nan, r1_inf, r1_inf_s;
    logic [EXP_W-1:0] r1_e;
    logic [XW-1:0]    r1_bx, r1_sx;
    logic             r2_v, r2_s, r2_nan, r2_inf, r2_inf_s;
    logic [EXP_W-1:0] r2_e;
    logic [SW-1:0]    r2_m;
    logic             r_out_valid, r_ovf, r_nan;
    logic [W-1:0]     r_sum;

    logic             w_en;
    fp_unp_t          w_ua, w_ub;
    logic             w_sb, w_swap, w_big_s, w_s1_nan, w_s1_inf, w_inf_s;
    logic [EXP_W-1:0] w_ea, w_eb, w_big_e, w_diff;
    logic [XW-1:0]    w_xa, w_xb, w_big_x, w_small_x, w_al;
    logic [2*XW-1:0]  w_sh;
    logic [SW-1:0]    w_m, w_t;
    logic [LW-1:0]    w_lz;
    logic [XW-1:0]    w_n;
    logic [EXP_W+1:0] w_e_new, w_e_fin;
    logic [MAN_W-1:0] w_man;
    logic             w_uf, w_of, w_ovf, w_nan;
    logic [W-1:0]     w_res;
    logic             w_unused;

    // One enable for every stage: the pipe only advances when the output slot frees up.
    assign w_en        = !r_out_valid | i_out_ready;
    assign o_in_ready  = w_en;
    assign o_out_valid = r_out_valid;
    assign o_sum       = r_sum;
    assign o_ovf       = r_ovf;
    assign o_nan       = r_nan;

    // S1: order by magnitude, then shift the smaller significand into guard/round/sticky.
    always_comb begin
        w_ua      = fp_unpack(64'(i_a), EXP_W, MAN_W);
        w_ub      = fp_unpack(64'(i_b), EXP_W, MAN_W);
        w_sb      = w_ub.sign ^ i_sub;
        w_ea      = w_ua.exp[EXP_W-1:0];
        w_eb      = w_ub.exp[EXP_W-1:0];
        w_xa      = {!w_ua.is_zero, w_ua.man[MAN_W-1:0], 3'b000};
        w_xb      = {!w_ub.is_zero, w_ub.man[MAN_W-1:0], 3'b000};
        w_swap    = {w_eb, w_xb} > {w_ea, w_xa};
        w_big_e   = w_swap ? w_eb : w_ea;
        w_big_s   = w_swap ? w_sb : w_ua.sign;
        w_big_x   = w_swap ? w_xb : w_xa;
        w_small_x = w_swap ? w_xa : w_xb;
        w_diff    = w_swap ? w_eb - w_ea : w_ea - w_eb;
        w_sh      = {w_small_x, {XW{1'b0}}} >> w_diff;
        w_al      = {w_sh[2*XW-1:XW+1], w_sh[XW] | (|w_sh[XW-1:0])};
        w_s1_nan  = w_ua.is_nan | w_ub.is_nan | (w_ua.is_inf & w_ub.is_inf & (w_ua.sign != w_sb));
        w_s1_inf  = w_ua.is_inf | w_ub.is_inf;
        w_inf_s   = w_ua.is_inf ? w_ua.sign : w_sb;
    end

    // S2: the larger magnitude is always the minuend, so the difference never goes negative.
    assign w_m = r1_sub ? ({1'b0, r1_bx} - {1'b0, r1_sx}) : ({1'b0, r1_bx} + {1'b0, r1_sx});

    fp_lzc #(.W(SW)) u_lzc (
        .i_d   (r2_m),
        .o_cnt (w_lz)
    );

    // S3: shifting by the full count puts the leading one at the carry position, so the
    // carry-out and cancellation cases share one path (drop one bit into sticky).
    always_comb begin
        w_t     = r2_m << w_lz;
        w_n     = {w_t[SW-1:2], w_t[1] | w_t[0]};
        w_e_new = {2'b00, r2_e} + (EXP_W+2)'(1) - (EXP_W+2)'(w_lz);
`ifdef FLOAT_ADD_RNE_EN
        begin
            logic             w_inc;
            logic [MAN_W+1:0] w_rnd;
            w_inc   = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
            w_rnd   = {1'b0, w_n[XW-1:3]} + (MAN_W+2)'(w_inc);
            w_man   = w_rnd[MAN_W-1:0];
            w_e_fin = w_e_new + (EXP_W+2)'(w_rnd[MAN_W+1]);
        end
`else
        w_man   = w_n[MAN_W+2:3];
        w_e_fin = w_e_new;
`endif
        w_uf  = w_e_new[EXP_W+1] | (w_e_new == '0) | (r2_m == '0);
        w_of  = !w_uf & (w_e_fin >= {2'b00, EMAX});
        w_nan = r2_nan;
        w_ovf = !r2_nan & !r2_inf & w_of;
        w_res = r2_nan ? QNAN :
                r2_inf ? {r2_inf_s, EMAX, {MAN_W{1'b0}}} :
                w_uf   ? '0 :
                w_of   ? {r2_s, EMAX, {MAN_W{1'b0}}} :
                         {r2_s, w_e_fin[EXP_W-1:0], w_man};
    end

    assign w_unused = ^{w_ua, w_ub, w_n};

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_v        <= 1'b0;
            r2_v        <= 1'b0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_nan       <= 1'b0;
        end else if (w_en) begin
            r1_v        <= i_in_valid;
            r1_s        <= w_big_s;
            r1_sub      <= w_ua.sign != w_sb;
            r1_e        <= w_big_e;
            r1_bx       <= w_big_x;
            r1_sx       <= w_al;
            r1_nan      <= w_s1_nan;
            r1_inf      <= w_s1_inf;
            r1_inf_s    <= w_inf_s;
            r2_v        <= r1_v;
            r2_s        <= r1_s;
            r2_e        <= r1_e;
            r2_m        <= w_m;
            r2_nan      <= r1_nan;
            r2_inf      <= r1_inf;
            r2_inf_s    <= r1_inf_s;
            r_out_valid <= r2_v;
            r_sum       <= w_res;
            r_ovf       <= w_ovf;
            r_nan       <= w_nan;
        end
    end

endmodule
